sd_sector_arbiter: RTL and testbench
====================================

Name: sd_sector_arbiter

Overview:
- Shares one SD-over-SPI sector engine between two requesters, client 0 and client 1.
- Each client asks for a single-sector read or write at a 32-bit sector address.
- The arbiter grants clients round-robin, issues a one-cycle start pulse with the address to the engine, and routes the engine's data handshakes to the owning client.
- It waits for the engine's busy to fall, then signals done or error to that client.
- It sits between the SD engine and application logic (test-pattern generator, logger).

Parameters:
- START_TMO, 16, cycles allowed after a start pulse for the engine's busy to rise before an error is declared.
- NCLI, 2, number of clients; fixed at 2 in this revision.

Ports:
- clk_sd  in  1  SD clock; all logic on its rising edge.
- reset_n  in  1  reset; synchronous, active-low.
- sd_init_done  in  1  engine initialisation complete (level).
- cli_req  in  2  per-client request level; held until cli_ack.
- cli_we  in  2  per-client direction; 1 = write, 0 = read.
- cli_addr0  in  32  client 0 sector address.
- cli_addr1  in  32  client 1 sector address.
- cli_ack  out  2  one-cycle pulse when the request is accepted.
- cli_done  out  2  one-cycle pulse on successful completion.
- cli_err  out  2  one-cycle pulse on start timeout.
- cli_wr_data0  in  16  client 0 write word.
- cli_wr_data1  in  16  client 1 write word.
- cli_wr_req  out  2  engine wr_req routed to the owner.
- cli_rd_en  out  2  engine rd_en routed to the owner.
- cli_rd_data  out  16  engine rd_data (broadcast).
- wr_busy  in  1  engine write busy.
- rd_busy  in  1  engine read busy.
- wr_req  in  1  engine asks for the next write word.
- rd_en  in  1  engine read word valid.
- rd_data  in  16  engine read word.
- wr_start_en  out  1  one-cycle write start pulse.
- wr_sec_addr  out  32  write sector address; held valid.
- wr_data  out  16  write word muxed from the owner.
- rd_start_en  out  1  one-cycle read start pulse.
- rd_sec_addr  out  32  read sector address; held valid.
- owner  out  1  current or last granted client.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0. Both addresses 0, owner 0, round-robin pointer 0, FSM in IDLE.
- States: IDLE -> START -> WAIT_BUSY -> XFER -> DONE -> IDLE.
- IDLE:
  - Waits until sd_init_done=1 and some cli_req bit is 1.
  - Picks the client whose index equals the pointer if it is requesting, else the other client.
  - Latches owner, we and addr. Pulses cli_ack[owner] for one cycle.
  - Next state is START.
- START:
  - One cycle. Drives wr_start_en=1 if we, else rd_start_en=1.
  - Loads the matching *_sec_addr with the latched address. The other start output stays 0.
  - Clears the timeout counter.
  - Latency: start pulse comes 1 cycle after ack, 2 cycles after the cycle in which the request is seen.
- WAIT_BUSY:
  - Selected busy (wr_busy if we, else rd_busy) = 1 -> go to XFER.
  - Counter reaching START_TMO-1 -> pulse cli_err[owner], go to IDLE, advance the pointer.
- XFER:
  - Stays until the selected busy is seen low.
  - busy=0 in the cycle after the 1 seen in WAIT_BUSY is still a valid fall.
- DONE:
  - Pulses cli_done[owner] for one cycle.
  - Pointer = ~owner. Next state is IDLE.
  - A new grant can occur on the following cycle.
- Routing (combinational, valid in every state):
  - wr_data = owner ? cli_wr_data1 : cli_wr_data0.
  - cli_wr_req[owner] = wr_req; cli_rd_en[owner] = rd_en.
  - The non-owner sees 0 on both.
- Simultaneous requests: the pointer decides. After a client is served (done or err), the other client has priority.
- A single persistent requester is re-granted back-to-back.
- sd_init_done falling mid-operation: the transaction completes normally; no new grant until it returns high.
- Dropping cli_req after ack is ignored. cli_we and cli_addr changes after ack are ignored.
- The wrong-direction busy is ignored in all states.
- reset_n low on any edge: FSM to IDLE, start pulses and all cli_* pulses cleared that cycle, pointer 0. An in-flight transaction is abandoned with no done.

Decomposition:
- Package sd_arb_pkg holds:
  - FSM state encoding (3-bit: IDLE, START, WAIT_BUSY, XFER, DONE).
  - Default START_TMO.
  - TEST sector address constant 2000 for benches.
- Sub-module sd_rr_pick2: 2-way round-robin selector. Inputs req[1:0] and ptr; outputs gnt_idx and gnt_valid. Purely combinational.

Test Plan:
- Reset then sd_init_done=1, client 0 write at sector 2000:
  - cli_ack[0] pulses, wr_start_en pulses 1 cycle later with wr_sec_addr=2000.
  - Model holds wr_busy high for 256 wr_req cycles; wr_data follows cli_wr_data0 (0..255).
  - cli_done[0] pulses after wr_busy falls.
- Both clients request in the same cycle with the pointer at 0:
  - Client 0 served first (read at 2000), then client 1 (write at 3000).
  - Client 1 then remains the only requester and is re-granted; no starvation.
- Client 1 read, model drives rd_en with rd_data 0..255:
  - cli_rd_en[1] mirrors rd_en; cli_rd_en[0] stays 0.
  - cli_done[1] pulses once.
- Start issued but the model never raises busy:
  - cli_err pulses exactly START_TMO cycles after the start pulse; FSM back in IDLE; no cli_done.
- cli_req asserted while sd_init_done=0:
  - No ack for 100 cycles; ack follows 1 cycle after sd_init_done rises.
- reset_n low during XFER:
  - Next cycle busy=0, start outputs 0, owner 0, no cli_done.
  - A fresh request after reset is accepted normally.

Source files
------------

// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the two-client SD sector arbiter.
package sd_arb_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StWaitBusy = 3'd2,
        StXfer     = 3'd3,
        StDone     = 3'd4
    } arb_state_e;

    localparam int unsigned START_TMO_DEFAULT = 16;

    // Sector used by benches as a known test target.
    localparam logic [31:0] TEST_SECTOR = 32'd2000;

endpackage

// File: rtl/sd_rr_pick2.sv
// Two-way round-robin selector: the pointed-at client wins if requesting.
module sd_rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       gnt_idx,
    output logic       gnt_valid
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = req[ptr] ? ptr : ~ptr;
    end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Shares one SD sector engine between two clients with round-robin grants,
// start-timeout detection and per-owner routing of the data handshakes.
module sd_sector_arbiter
    import sd_arb_pkg::*;
#(
    parameter int unsigned START_TMO = START_TMO_DEFAULT,
    parameter int unsigned NCLI      = 2
) (
    input  logic            clk_sd,
    input  logic            reset_n,
    input  logic            sd_init_done,
    input  logic [NCLI-1:0] cli_req,
    input  logic [NCLI-1:0] cli_we,
    input  logic [31:0]     cli_addr0,
    input  logic [31:0]     cli_addr1,
    output logic [NCLI-1:0] cli_ack,
    output logic [NCLI-1:0] cli_done,
    output logic [NCLI-1:0] cli_err,
    input  logic [15:0]     cli_wr_data0,
    input  logic [15:0]     cli_wr_data1,
    output logic [NCLI-1:0] cli_wr_req,
    output logic [NCLI-1:0] cli_rd_en,
    output logic [15:0]     cli_rd_data,
    input  logic            wr_busy,
    input  logic            rd_busy,
    input  logic            wr_req,
    input  logic            rd_en,
    input  logic [15:0]     rd_data,
    output logic            wr_start_en,
    output logic [31:0]     wr_sec_addr,
    output logic [15:0]     wr_data,
    output logic            rd_start_en,
    output logic [31:0]     rd_sec_addr,
    output logic            owner,
    output logic            busy
);

    localparam int unsigned TmoW = (START_TMO > 1) ? $clog2(START_TMO) : 1;

    arb_state_e      state_q, state_d;
    logic            ptr_q, ptr_d;
    logic            owner_q, owner_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [NCLI-1:0] ack_q, ack_d;
    logic [NCLI-1:0] done_q, done_d;
    logic [NCLI-1:0] err_q, err_d;
    logic            wr_start_q, wr_start_d;
    logic            rd_start_q, rd_start_d;
    logic [31:0]     wr_addr_q, wr_addr_d;
    logic [31:0]     rd_addr_q, rd_addr_d;

    logic gnt_idx;
    logic gnt_valid;
    logic sel_busy;

    sd_rr_pick2 u_pick (
        .req      (cli_req),
        .ptr      (ptr_q),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid)
    );

    // Only the busy matching the latched direction is ever looked at.
    assign sel_busy = we_q ? wr_busy : rd_busy;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        tmo_d      = tmo_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        ack_d      = '0;
        done_d     = '0;
        err_d      = '0;
        wr_start_d = 1'b0;
        rd_start_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (sd_init_done && gnt_valid) begin
                    owner_d        = gnt_idx;
                    we_d           = cli_we[gnt_idx];
                    addr_d         = gnt_idx ? cli_addr1 : cli_addr0;
                    ack_d[gnt_idx] = 1'b1;
                    state_d        = StStart;
                end
            end
            StStart: begin
                tmo_d = '0;
                if (we_q) begin
                    wr_start_d = 1'b1;
                    wr_addr_d  = addr_q;
                end else begin
                    rd_start_d = 1'b1;
                    rd_addr_d  = addr_q;
                end
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (sel_busy) begin
                    state_d = StXfer;
                end else if (tmo_q == TmoW'(START_TMO - 1)) begin
                    err_d[owner_q] = 1'b1;
                    ptr_d          = ~owner_q;
                    state_d        = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StXfer: begin
                if (!sel_busy) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_d[owner_q] = 1'b1;
                ptr_d           = ~owner_q;
                state_d         = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_sd) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            ptr_q      <= 1'b0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            tmo_q      <= '0;
            ack_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
            wr_start_q <= 1'b0;
            rd_start_q <= 1'b0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            tmo_q      <= tmo_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wr_start_q <= wr_start_d;
            rd_start_q <= rd_start_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    always_comb begin
        cli_wr_req          = '0;
        cli_rd_en           = '0;
        cli_wr_req[owner_q] = wr_req;
        cli_rd_en[owner_q]  = rd_en;
    end

    assign wr_data     = owner_q ? cli_wr_data1 : cli_wr_data0;
    assign cli_rd_data = rd_data;
    assign cli_ack     = ack_q;
    assign cli_done    = done_q;
    assign cli_err     = err_q;
    assign wr_start_en = wr_start_q;
    assign rd_start_en = rd_start_q;
    assign wr_sec_addr = wr_addr_q;
    assign rd_sec_addr = rd_addr_q;
    assign owner       = owner_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Bench for sd_sector_arbiter: behavioural engine model plus a transaction-level
// round-robin reference that predicts grant order, latencies and routing.
module tb_sd_sector_arbiter;
    import sd_arb_pkg::*;

    localparam int TMO = START_TMO_DEFAULT;

    logic        clk_sd = 1'b0;
    logic        reset_n;
    logic        sd_init_done;
    logic [1:0]  cli_req;
    logic [1:0]  cli_we;
    logic [31:0] cli_addr0;
    logic [31:0] cli_addr1;
    logic [1:0]  cli_ack;
    logic [1:0]  cli_done;
    logic [1:0]  cli_err;
    logic [15:0] cli_wr_data0;
    logic [15:0] cli_wr_data1;
    logic [1:0]  cli_wr_req;
    logic [1:0]  cli_rd_en;
    logic [15:0] cli_rd_data;
    logic        wr_busy;
    logic        rd_busy;
    logic        wr_req;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        wr_start_en;
    logic [31:0] wr_sec_addr;
    logic [15:0] wr_data;
    logic        rd_start_en;
    logic [31:0] rd_sec_addr;
    logic        owner;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;

    sd_sector_arbiter dut (
        .clk_sd      (clk_sd),
        .reset_n     (reset_n),
        .sd_init_done(sd_init_done),
        .cli_req     (cli_req),
        .cli_we      (cli_we),
        .cli_addr0   (cli_addr0),
        .cli_addr1   (cli_addr1),
        .cli_ack     (cli_ack),
        .cli_done    (cli_done),
        .cli_err     (cli_err),
        .cli_wr_data0(cli_wr_data0),
        .cli_wr_data1(cli_wr_data1),
        .cli_wr_req  (cli_wr_req),
        .cli_rd_en   (cli_rd_en),
        .cli_rd_data (cli_rd_data),
        .wr_busy     (wr_busy),
        .rd_busy     (rd_busy),
        .wr_req      (wr_req),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .wr_start_en (wr_start_en),
        .wr_sec_addr (wr_sec_addr),
        .wr_data     (wr_data),
        .rd_start_en (rd_start_en),
        .rd_sec_addr (rd_sec_addr),
        .owner       (owner),
        .busy        (busy)
    );

    always #5 clk_sd = ~clk_sd;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_sd);
        #1;
    endtask

    function automatic logic [1:0] onehot(input int cli);
        logic [1:0] v;
        v = 2'b00;
        v[cli] = 1'b1;
        return v;
    endfunction

    // Reference arbitration rule: the pointed-at client wins if requesting.
    function automatic int model_pick();
        return cli_req[model_ptr] ? model_ptr : 1 - model_ptr;
    endfunction

    task automatic post_req(input int cli, input logic we, input logic [31:0] addr);
        cli_we[cli]  = we;
        cli_req[cli] = 1'b1;
        if (cli == 0) cli_addr0 = addr;
        else          cli_addr1 = addr;
    endtask

    task automatic expect_ack(input int cli, input int max_wait, input bit drop);
        bit seen = 1'b0;
        int n = 0;
        while (n < max_wait && !seen) begin
            step();
            n++;
            if (cli_ack != 2'b00) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ack_wait: cli_ack=%b after %0d cycles, required %b", cli_ack, n,
                     onehot(cli));
        end else begin
            checks++;
            if (cli_ack !== onehot(cli)) begin
                errors++;
                $display("FAIL ack_target: cli_ack=%b, required %b", cli_ack, onehot(cli));
            end
            checks++;
            if (owner !== cli[0]) begin
                errors++;
                $display("FAIL ack_owner: owner=%b, required %0d", owner, cli);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL ack_busy: busy=%b, required 1", busy);
            end
        end
        if (drop) begin
            // Post-ack changes to direction and address must not matter.
            cli_req[cli] = 1'b0;
            cli_we[cli]  = 1'($urandom);
            if (cli == 0) cli_addr0 = $urandom;
            else          cli_addr1 = $urandom;
        end
    endtask

    // Runs one granted transaction from the start pulse through done.
    task automatic serve(input int cli, input logic we, input logic [31:0] addr,
                         input int nwords);
        logic [1:0] exp_start;
        logic [31:0] got_addr;
        step();
        exp_start = we ? 2'b10 : 2'b01;
        got_addr  = we ? wr_sec_addr : rd_sec_addr;
        checks++;
        if ({wr_start_en, rd_start_en} !== exp_start) begin
            errors++;
            $display("FAIL start_pulse: {wr,rd}_start=%b, required %b",
                     {wr_start_en, rd_start_en}, exp_start);
        end
        checks++;
        if (got_addr !== addr) begin
            errors++;
            $display("FAIL sec_addr: got %0d, required %0d", got_addr, addr);
        end
        checks++;
        if (cli_ack !== 2'b00) begin
            errors++;
            $display("FAIL ack_width: cli_ack=%b, required 00", cli_ack);
        end
        if (we) wr_busy = 1'b1;
        else    rd_busy = 1'b1;
        step();
        checks++;
        if ({wr_start_en, rd_start_en} !== 2'b00) begin
            errors++;
            $display("FAIL start_width: {wr,rd}_start=%b, required 00",
                     {wr_start_en, rd_start_en});
        end
        for (int k = 0; k < nwords; k++) begin
            if (we) begin
                wr_req = 1'b1;
                if (cli == 0) begin
                    cli_wr_data0 = 16'(k);
                    cli_wr_data1 = 16'(~k);
                end else begin
                    cli_wr_data1 = 16'(k);
                    cli_wr_data0 = 16'(~k);
                end
            end else begin
                rd_en   = 1'b1;
                rd_data = 16'(k);
            end
            #1;
            checks++;
            if (cli_wr_req !== (we ? onehot(cli) : 2'b00)) begin
                errors++;
                $display("FAIL wr_req_route: cli_wr_req=%b word %0d, required %b", cli_wr_req,
                         k, we ? onehot(cli) : 2'b00);
            end
            checks++;
            if (cli_rd_en !== (we ? 2'b00 : onehot(cli))) begin
                errors++;
                $display("FAIL rd_en_route: cli_rd_en=%b word %0d, required %b", cli_rd_en, k,
                         we ? 2'b00 : onehot(cli));
            end
            checks++;
            if (we ? (wr_data !== 16'(k)) : (cli_rd_data !== 16'(k))) begin
                errors++;
                $display("FAIL data_route: wr_data=%0d rd_data=%0d, required %0d", wr_data,
                         cli_rd_data, k);
            end
            step();
        end
        wr_req  = 1'b0;
        rd_en   = 1'b0;
        wr_busy = 1'b0;
        rd_busy = 1'b0;
        step();
        checks++;
        if (cli_done !== 2'b00) begin
            errors++;
            $display("FAIL done_early: cli_done=%b, required 00", cli_done);
        end
        step();
        checks++;
        if (cli_done !== onehot(cli) || cli_err !== 2'b00) begin
            errors++;
            $display("FAIL done_pulse: cli_done=%b cli_err=%b, required %b/00", cli_done,
                     cli_err, onehot(cli));
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL done_idle: busy=%b, required 0", busy);
        end
        model_ptr = 1 - cli;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n   = 1'b1;
        model_ptr = 0;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        sd_init_done = 1'b0;
        cli_req      = '0;
        cli_we       = '0;
        cli_addr0    = '0;
        cli_addr1    = '0;
        cli_wr_data0 = '0;
        cli_wr_data1 = '0;
        wr_busy      = 1'b0;
        rd_busy      = 1'b0;
        wr_req       = 1'b0;
        rd_en        = 1'b0;
        rd_data      = '0;
        step();
        step();
        step();
        checks++;
        if ({cli_ack, cli_done, cli_err, cli_wr_req, cli_rd_en} !== 10'd0) begin
            errors++;
            $display("FAIL reset_cli: ack/done/err/wr_req/rd_en=%b, required 0",
                     {cli_ack, cli_done, cli_err, cli_wr_req, cli_rd_en});
        end
        checks++;
        if ({wr_start_en, rd_start_en, owner, busy} !== 4'd0 || wr_sec_addr !== 32'd0 ||
            rd_sec_addr !== 32'd0 || wr_data !== 16'd0 || cli_rd_data !== 16'd0) begin
            errors++;
            $display("FAIL reset_eng: starts/owner/busy=%b addrs=%0d/%0d, required 0",
                     {wr_start_en, rd_start_en, owner, busy}, wr_sec_addr, rd_sec_addr);
        end
        reset_n   = 1'b1;
        model_ptr = 0;
    endtask

    task automatic test_write_c0();
        sd_init_done = 1'b1;
        post_req(0, 1'b1, TEST_SECTOR);
        expect_ack(0, 4, 1'b1);
        serve(0, 1'b1, TEST_SECTOR, 256);
        step();
        checks++;
        if (cli_done !== 2'b00) begin
            errors++;
            $display("FAIL done_once_wr: cli_done=%b, required 00", cli_done);
        end
    endtask

    task automatic test_simultaneous();
        int first;
        apply_reset();
        post_req(0, 1'b0, TEST_SECTOR);
        post_req(1, 1'b1, 32'd3000);
        first = model_pick();
        expect_ack(first, 4, 1'b1);
        serve(first, 1'b0, TEST_SECTOR, 8);
        expect_ack(1, 1, 1'b0);
        serve(1, 1'b1, 32'd3000, 8);
        // Sole persistent requester is granted again immediately.
        expect_ack(model_pick(), 1, 1'b1);
        serve(1, 1'b1, 32'd3000, 4);
    endtask

    task automatic test_read_c1();
        logic [31:0] a;
        a = $urandom;
        post_req(1, 1'b0, a);
        expect_ack(model_pick(), 4, 1'b1);
        serve(1, 1'b0, a, 256);
        for (int n = 0; n < 5; n++) begin
            step();
            checks++;
            if (cli_done !== 2'b00 || cli_rd_en[0] !== 1'b0) begin
                errors++;
                $display("FAIL done_once_rd: cli_done=%b cli_rd_en=%b, required 00/x0",
                         cli_done, cli_rd_en);
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] a;
        a = $urandom;
        post_req(0, 1'b1, a);
        expect_ack(model_pick(), 4, 1'b1);
        step();
        checks++;
        if (wr_start_en !== 1'b1 || wr_sec_addr !== a) begin
            errors++;
            $display("FAIL tmo_start: wr_start_en=%b addr=%0d, required 1/%0d", wr_start_en,
                     wr_sec_addr, a);
        end
        rd_busy = 1'b1;  // wrong direction for a write
        for (int n = 1; n <= TMO; n++) begin
            step();
            checks++;
            if (n < TMO) begin
                if (cli_err !== 2'b00 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL tmo_early: cycle %0d cli_err=%b busy=%b, required 00/1", n,
                             cli_err, busy);
                end
            end else if (cli_err !== 2'b01 || busy !== 1'b0 || cli_done !== 2'b00) begin
                errors++;
                $display("FAIL tmo_err: cli_err=%b busy=%b cli_done=%b, required 01/0/00",
                         cli_err, busy, cli_done);
            end
        end
        rd_busy   = 1'b0;
        model_ptr = 1;
        for (int n = 0; n < 4; n++) begin
            step();
            checks++;
            if (cli_done !== 2'b00 || cli_err !== 2'b00) begin
                errors++;
                $display("FAIL tmo_after: cli_done=%b cli_err=%b, required 00/00", cli_done,
                         cli_err);
            end
        end
    endtask

    task automatic test_init_gate();
        logic [31:0] a;
        a = $urandom;
        sd_init_done = 1'b0;
        post_req(0, 1'b0, a);
        for (int n = 0; n < 100; n++) begin
            step();
            checks++;
            if (cli_ack !== 2'b00) begin
                errors++;
                $display("FAIL init_gate: cycle %0d cli_ack=%b, required 00", n, cli_ack);
            end
        end
        sd_init_done = 1'b1;
        expect_ack(0, 1, 1'b1);
        sd_init_done = 1'b0;  // falls mid-operation; transaction still completes
        serve(0, 1'b0, a, 3);
        a = $urandom;
        post_req(1, 1'b1, a);
        for (int n = 0; n < 10; n++) begin
            step();
            checks++;
            if (cli_ack !== 2'b00) begin
                errors++;
                $display("FAIL init_regate: cycle %0d cli_ack=%b, required 00", n, cli_ack);
            end
        end
        sd_init_done = 1'b1;
        expect_ack(1, 1, 1'b1);
        serve(1, 1'b1, a, 3);
    endtask

    task automatic test_reset_mid();
        logic [31:0] a;
        a = $urandom;
        post_req(1, 1'b1, a);
        expect_ack(model_pick(), 4, 1'b1);
        step();
        wr_busy = 1'b1;
        step();
        wr_req = 1'b1;
        step();
        step();
        reset_n = 1'b0;
        step();
        checks++;
        if ({busy, wr_start_en, rd_start_en, owner} !== 4'd0 || cli_done !== 2'b00 ||
            cli_ack !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid: busy/starts/owner=%b cli_done=%b, required 0000/00",
                     {busy, wr_start_en, rd_start_en, owner}, cli_done);
        end
        reset_n   = 1'b1;
        wr_busy   = 1'b0;
        wr_req    = 1'b0;
        model_ptr = 0;
        for (int n = 0; n < 4; n++) begin
            step();
            checks++;
            if (cli_done !== 2'b00 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_abandon: cli_done=%b busy=%b, required 00/0", cli_done,
                         busy);
            end
        end
        a = $urandom;
        post_req(1, 1'b0, a);
        expect_ack(model_pick(), 4, 1'b1);
        serve(1, 1'b0, a, 4);
    endtask

    task automatic test_back_to_back();
        logic        exp_we   [2];
        logic [31:0] exp_addr [2];
        int mask;
        int first;
        int other;
        for (int it = 0; it < 10; it++) begin
            mask = $urandom_range(1, 3);
            for (int i = 0; i < 2; i++) begin
                if (mask[i]) begin
                    exp_we[i]   = 1'($urandom);
                    exp_addr[i] = $urandom;
                    post_req(i, exp_we[i], exp_addr[i]);
                end
            end
            first = model_pick();
            expect_ack(first, 4, 1'b1);
            serve(first, exp_we[first], exp_addr[first], $urandom_range(0, 5));
            if (mask == 3) begin
                other = 1 - first;
                expect_ack(other, 1, 1'b1);
                serve(other, exp_we[other], exp_addr[other], $urandom_range(0, 5));
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_c0();
        test_simultaneous();
        test_read_c1();
        test_timeout();
        test_init_gate();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
